// File: rtl/cic_comp_pkg.sv
// Shared definitions for the CIC compensation FIR.
//   DEFAULT_COEF : reset value of every tap; with 16 taps in Q2.16 the
//                  taps sum to 1.0, a unity-gain boxcar
//   state_t      : sequencer states
//   acc_width()  : accumulator width that cannot wrap for a given sample
//                  width, coefficient width and tap count
package cic_comp_pkg;

  localparam int unsigned DEFAULT_COEF = 4096;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } state_t;

  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/cic_comp_coef_ram.sv
// Coefficient register file: NTAPS entries of COEF_WIDTH bits, one
// synchronous write port and one asynchronous read port. Every entry
// returns to DEFAULT_COEF on reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   we_i       : write enable (already qualified by the caller)
//   waddr_i    : write tap index
//   wdata_i    : write coefficient
//   raddr_i    : read tap index
//   rdata_o    : coefficient at raddr_i (0 for out-of-range indices)
module cic_comp_coef_ram
  import cic_comp_pkg::*;
#(
  parameter int unsigned NTAPS      = 16,
  parameter int unsigned COEF_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH = $clog2(NTAPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [COEF_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [COEF_WIDTH-1:0] rdata_o
);

  logic [COEF_WIDTH-1:0] mem_q [NTAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        mem_q[i] <= COEF_WIDTH'(DEFAULT_COEF);
      end
    end else if (we_i && (32'(waddr_i) < NTAPS)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (32'(raddr_i) < NTAPS) begin
      rdata_o = mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// Time-multiplexed compensation FIR with output decimation, placed after
// a CIC decimator. One multiply-accumulate walks all NTAPS taps per
// output, then the result is rounded, saturated to DATA_WIDTH and offered
// on an AXI-Stream master.
//   clk, rst_n       : single clock, asynchronous active-low reset
//   S_AXIS_tdata     : input sample in tdata[DATA_WIDTH-1:0], signed
//   S_AXIS_tvalid    : input valid
//   S_AXIS_tready    : input ready, high only while idle
//   M_AXIS_tdata     : filtered sample, sign-extended (SE=1) or zero-padded
//   M_AXIS_tvalid    : output valid, held until M_AXIS_tready
//   M_AXIS_tready    : output ready
//   coef_wr          : coefficient write strobe, honoured only while idle
//   coef_addr        : tap index for the write
//   coef_data        : signed coefficient, Q2.16 by default
//   busy             : high whenever the sequencer is not idle
//   sat              : one-cycle pulse alongside an output that saturated
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned DATA_WIDTH       = 14,
  parameter int unsigned NTAPS            = 16,
  parameter int unsigned COEF_WIDTH       = 18,
  parameter int unsigned COEF_FRAC        = 16,
  parameter int unsigned DECIM            = 2,
  parameter bit          SE               = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  input  logic                        coef_wr,
  input  logic [$clog2(NTAPS)-1:0]    coef_addr,
  input  logic [COEF_WIDTH-1:0]       coef_data,
  output logic                        busy,
  output logic                        sat
);

  localparam int unsigned AW     = $clog2(NTAPS);
  localparam int unsigned ACC_W  = acc_width(DATA_WIDTH, COEF_WIDTH, NTAPS);
  localparam int unsigned PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int unsigned PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned PAD_W  = AXIS_TDATA_WIDTH - DATA_WIDTH;

  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(64'd1 << (COEF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
  // Bitwise inverse of 2^(N-1)-1 is -2^(N-1).
  localparam logic signed [ACC_W-1:0] SAT_MIN    = ~SAT_MAX;

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  state_t state_q, state_d;

  logic            in_ready;
  logic            accept;
  logic            trigger;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [AW-1:0]   k_q;

  assign accept  = S_AXIS_tvalid && in_ready;
  assign trigger = (phase_q == PH_W'(DECIM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && trigger) state_d = MAC;
      MAC:     if (k_q == AW'(NTAPS - 1)) state_d = ROUND;
      ROUND:   state_d = OUT;
      OUT:     if (M_AXIS_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    if (state_q == IDLE) begin
      in_ready = 1'b1;
      busy     = 1'b0;
    end
  end

  assign S_AXIS_tready = in_ready;

  always_comb begin
    phase_d = phase_q;
    if (accept) begin
      phase_d = trigger ? '0 : phase_q + PH_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Coefficients
  // ---------------------------------------------------------------------
  logic [COEF_WIDTH-1:0] coef_rd;

  cic_comp_coef_ram #(
    .NTAPS      (NTAPS),
    .COEF_WIDTH (COEF_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_coef_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (coef_wr && (state_q == IDLE)),
    .waddr_i (coef_addr),
    .wdata_i (coef_data),
    .raddr_i (k_q),
    .rdata_o (coef_rd)
  );

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] x_q [NTAPS];
  logic signed [DATA_WIDTH-1:0] sample_in;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      acc_q;
  logic signed [ACC_W-1:0]      rounded;
  logic signed [DATA_WIDTH-1:0] y_sat;
  logic                         sat_det;
  logic [AXIS_TDATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                         tvalid_q;
  logic                         sat_q;
  logic                         unused_tdata_hi;

  assign sample_in       = S_AXIS_tdata[DATA_WIDTH-1:0];
  assign unused_tdata_hi = ^S_AXIS_tdata[AXIS_TDATA_WIDTH-1:DATA_WIDTH];

  always_comb begin
    prod = PROD_W'($signed(coef_rd)) * PROD_W'(x_q[k_q]);
  end

  always_comb begin
    rounded = (acc_q + ROUND_HALF) >>> COEF_FRAC;
    sat_det = 1'b0;
    y_sat   = rounded[DATA_WIDTH-1:0];
    if (rounded > SAT_MAX) begin
      y_sat   = SAT_MAX[DATA_WIDTH-1:0];
      sat_det = 1'b1;
    end else if (rounded < SAT_MIN) begin
      y_sat   = SAT_MIN[DATA_WIDTH-1:0];
      sat_det = 1'b1;
    end
    tdata_d = {{PAD_W{SE & y_sat[DATA_WIDTH-1]}}, y_sat};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
      end
      phase_q  <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      sat_q   <= 1'b0;
      phase_q <= phase_d;
      if (accept) begin
        for (int unsigned i = 1; i < NTAPS; i++) begin
          x_q[i] <= x_q[i-1];
        end
        x_q[0] <= sample_in;
      end
      unique case (state_q)
        IDLE: begin
          k_q <= '0;
          if (accept && trigger) acc_q <= '0;
        end
        MAC: begin
          acc_q <= acc_q + ACC_W'(prod);
          k_q   <= k_q + AW'(1);
        end
        ROUND: begin
          tdata_q  <= tdata_d;
          tvalid_q <= 1'b1;
          sat_q    <= sat_det;
        end
        OUT: begin
          if (M_AXIS_tready) tvalid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign M_AXIS_tdata  = tdata_q;
  assign M_AXIS_tvalid = tvalid_q;
  assign sat           = sat_q;

endmodule
